// File: rtl/grid_scan_renderer_if.sv
// Pixel record stream from the grid scanner to the display writer.
interface grid_scan_renderer_if #(
  parameter int COORD_W = 4
);
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [1:0]         pix_code;
  logic               pix_last;

  modport master (
    output pix_valid, pix_x, pix_y, pix_code, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_code, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/grid_scan_renderer.sv
// Row-major playfield scanner: classifies every cell from the head/body/apple flags and
// streams changed cells (or all cells on full refresh) to the display writer.
module grid_scan_renderer #(
  parameter int COORD_W = 4
) (
  input  logic                 system_clk,
  input  logic                 nreset,
  input  logic                 frame_start,
  input  logic                 full_refresh,
  output logic [COORD_W-1:0]   x,
  output logic [COORD_W-1:0]   y,
  input  logic                 head,
  input  logic                 body,
  input  logic                 apple,
  grid_scan_renderer_if.master pix,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int NUM_CELLS = 2 ** (2 * COORD_W);
  localparam logic [COORD_W-1:0] MAX_COORD = {COORD_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       state;
  logic                         refresh_q;
  logic [NUM_CELLS-1:0][1:0]    shadow;
  logic [1:0]                   code;
  logic [2*COORD_W-1:0]         cell_idx;
  logic [2*COORD_W-1:0]         pix_idx;
  logic                         last_cell;
  logic                         changed;
  logic [COORD_W-1:0]           next_x;
  logic [COORD_W-1:0]           next_y;

  // Cell classification with head > body > apple > empty priority
  always_comb begin
    if (head) begin
      code = 2'b11;
    end else if (body) begin
      code = 2'b10;
    end else if (apple) begin
      code = 2'b01;
    end else begin
      code = 2'b00;
    end
  end

  assign cell_idx  = {y, x};
  assign pix_idx   = {pix.pix_y, pix.pix_x};
  assign last_cell = (x == MAX_COORD) && (y == MAX_COORD);
  assign changed   = refresh_q || (code != shadow[cell_idx]);
  assign next_x    = x + COORD_W'(1);
  assign next_y    = (x == MAX_COORD) ? (y + COORD_W'(1)) : y;

  // Scan FSM; the shadow only learns a code once the writer has accepted it
  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      refresh_q     <= 1'b0;
      x             <= '0;
      y             <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      pix.pix_valid <= 1'b0;
      pix.pix_x     <= '0;
      pix.pix_y     <= '0;
      pix.pix_code  <= 2'b00;
      pix.pix_last  <= 1'b0;
      shadow        <= '0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (frame_start) begin
            refresh_q <= full_refresh;
            x         <= '0;
            y         <= '0;
            busy      <= 1'b1;
            state     <= QUERY;
          end
        end
        QUERY: begin
          if (changed) begin
            pix.pix_x     <= x;
            pix.pix_y     <= y;
            pix.pix_code  <= code;
            pix.pix_last  <= last_cell;
            pix.pix_valid <= 1'b1;
            state         <= EMIT;
          end else if (last_cell) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            x <= next_x;
            y <= next_y;
          end
        end
        EMIT: begin
          if (pix.pix_ready) begin
            shadow[pix_idx] <= pix.pix_code;
            pix.pix_valid   <= 1'b0;
            if (pix.pix_last) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              x     <= next_x;
              y     <= next_y;
              state <= QUERY;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          x          <= '0;
          y          <= '0;
          state      <= IDLE;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          frame_done    <= 1'b0;
          pix.pix_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_grid_scan_renderer.sv
// Self-checking bench for grid_scan_renderer: directed sequences, a classification table
// and randomized boards compared against a frame-level reference model.
module tb_grid_scan_renderer;
  localparam int COORD_W = 4;
  localparam int N = 256;

  logic system_clk = 1'b0;
  logic nreset = 1'b0;
  logic frame_start = 1'b0;
  logic full_refresh = 1'b0;
  logic [COORD_W-1:0] x, y;
  logic head, body, apple, busy, frame_done;

  grid_scan_renderer_if #(.COORD_W(COORD_W)) pix ();

  grid_scan_renderer #(.COORD_W(COORD_W)) dut (
    .system_clk   (system_clk),
    .nreset       (nreset),
    .frame_start  (frame_start),
    .full_refresh (full_refresh),
    .x            (x),
    .y            (y),
    .head         (head),
    .body         (body),
    .apple        (apple),
    .pix          (pix.master),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 system_clk = ~system_clk;

  // Board seen by the scanner
  bit head_map [N];
  bit body_map [N];
  bit apple_map[N];
  int model_shadow[N];

  assign head  = head_map[{y, x}];
  assign body  = body_map[{y, x}];
  assign apple = apple_map[{y, x}];

  logic ready_mode = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_ready = 1'b1;
  assign pix.pix_ready = ready_mode ? rnd_ready : ready_force;

  always @(posedge system_clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  int cyc = 0;
  always @(posedge system_clk) cyc <= cyc + 1;

  typedef struct { int px; int py; int code; bit last; int cyc; } rec_t;
  typedef struct { int px; int py; int code; } want_t;
  rec_t  rec_q[$];
  want_t want_q[$];

  int total = 0;
  int bad = 0;
  int valid_cycles, done_cnt, done_cyc, busy_low, start_cyc;
  bit in_frame = 1'b0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Stream monitor: records handshakes and checks that stalled records hold still
  bit stall_prev = 1'b0;
  int prev_px, prev_py, prev_code, prev_x, prev_y;
  always @(negedge system_clk) begin
    if (nreset) begin
      if (stall_prev) begin
        check("stall_valid", int'(pix.pix_valid), 1);
        check("stall_pix_x", int'(pix.pix_x), prev_px);
        check("stall_pix_y", int'(pix.pix_y), prev_py);
        check("stall_code", int'(pix.pix_code), prev_code);
        check("stall_x", int'(x), prev_x);
        check("stall_y", int'(y), prev_y);
      end
      if (pix.pix_valid && pix.pix_ready)
        rec_q.push_back('{int'(pix.pix_x), int'(pix.pix_y), int'(pix.pix_code), pix.pix_last, cyc});
      if (pix.pix_valid) valid_cycles++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_frame && !busy && !frame_done) busy_low++;
      stall_prev = pix.pix_valid && !pix.pix_ready;
      prev_px = int'(pix.pix_x);
      prev_py = int'(pix.pix_y);
      prev_code = int'(pix.pix_code);
      prev_x = int'(x);
      prev_y = int'(y);
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic int code_of(int i);
    if (head_map[i]) return 3;
    if (body_map[i]) return 2;
    if (apple_map[i]) return 1;
    return 0;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < N; i++) begin
      head_map[i] = 1'b0;
      body_map[i] = 1'b0;
      apple_map[i] = 1'b0;
    end
  endtask

  task automatic place(input int cx, input int cy, input bit h, input bit b, input bit a);
    if (h) head_map[cy*16 + cx] = 1'b1;
    if (b) body_map[cy*16 + cx] = 1'b1;
    if (a) apple_map[cy*16 + cx] = 1'b1;
  endtask

  task automatic start_frame(input bit refresh);
    want_q.delete();
    for (int i = 0; i < N; i++) begin
      if (refresh || code_of(i) != model_shadow[i])
        want_q.push_back('{i % 16, i / 16, code_of(i)});
    end
    @(posedge system_clk);
    #1;
    rec_q.delete();
    valid_cycles = 0;
    done_cnt = 0;
    busy_low = 0;
    frame_start = 1'b1;
    full_refresh = refresh;
    start_cyc = cyc;
    @(posedge system_clk);
    #1;
    frame_start = 1'b0;
    full_refresh = 1'b0;
    in_frame = 1'b1;
  endtask

  task automatic finish_frame(input string tag);
    int guard;
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      @(negedge system_clk);
      #1;
      guard++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_count"}, rec_q.size(), want_q.size());
    for (int i = 0; i < rec_q.size() && i < want_q.size(); i++) begin
      check({tag, "_px"}, rec_q[i].px, want_q[i].px);
      check({tag, "_py"}, rec_q[i].py, want_q[i].py);
      check({tag, "_code"}, rec_q[i].code, want_q[i].code);
      check({tag, "_last"}, int'(rec_q[i].last), int'(want_q[i].px == 15 && want_q[i].py == 15));
    end
    foreach (want_q[i]) model_shadow[want_q[i].py*16 + want_q[i].px] = want_q[i].code;
    @(negedge system_clk);
    check({tag, "_done_pulse"}, int'(frame_done), 0);
    in_frame = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_valid"}, int'(pix.pix_valid), 0);
    check({tag, "_pix_x"}, int'(pix.pix_x), 0);
    check({tag, "_pix_y"}, int'(pix.pix_y), 0);
    check({tag, "_code"}, int'(pix.pix_code), 0);
    check({tag, "_last"}, int'(pix.pix_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(frame_done), 0);
  endtask

  typedef struct { int cx; int cy; bit h; bit b; bit a; int code; } vec_t;
  vec_t table_v[8];

  initial begin
    int guard;
    bit seen;
    table_v[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
    table_v[1] = '{5, 5, 1'b1, 1'b1, 1'b0, 3};
    table_v[2] = '{6, 5, 1'b1, 1'b0, 1'b1, 3};
    table_v[3] = '{7, 5, 1'b0, 1'b1, 1'b1, 2};
    table_v[4] = '{8, 5, 1'b0, 1'b0, 1'b1, 1};
    table_v[5] = '{9, 5, 1'b0, 1'b1, 1'b0, 2};
    table_v[6] = '{10, 5, 1'b1, 1'b0, 1'b0, 3};
    table_v[7] = '{15, 15, 1'b1, 1'b1, 1'b1, 3};
    for (int i = 0; i < N; i++) model_shadow[i] = 0;
    clear_board();

    repeat (3) @(posedge system_clk);
    #1;
    check_reset_outputs("rst0");
    nreset = 1'b1;

    // Frame 1: full refresh of the starting snake
    place(3, 2, 1'b1, 1'b0, 1'b0);
    place(2, 2, 1'b0, 1'b1, 1'b0);
    place(1, 2, 1'b0, 1'b1, 1'b0);
    place(9, 9, 1'b0, 1'b0, 1'b1);
    start_frame(1'b1);
    finish_frame("f1");
    check("f1_n", rec_q.size(), 256);
    if (rec_q.size() == 256) begin
      check("f1_head32", rec_q[35].code, 3);
      check("f1_body22", rec_q[34].code, 2);
      check("f1_body12", rec_q[33].code, 2);
      check("f1_apple99", rec_q[153].code, 1);
      check("f1_empty00", rec_q[0].code, 0);
      check("f1_done_lat", done_cyc, rec_q[255].cyc + 1);
    end

    // Frame 2: unchanged board, diff mode
    start_frame(1'b0);
    finish_frame("f2");
    check("f2_valid_cycles", valid_cycles, 0);
    check("f2_done_lat", done_cyc - start_cyc, 257);
    check("f2_busy_low", busy_low, 0);

    // Frame 3: snake moves, first record stalled for 10 cycles
    clear_board();
    place(4, 2, 1'b1, 1'b0, 1'b0);
    place(3, 2, 1'b0, 1'b1, 1'b0);
    place(2, 2, 1'b0, 1'b1, 1'b0);
    place(9, 9, 1'b0, 1'b0, 1'b1);
    ready_force = 1'b0;
    start_frame(1'b0);
    guard = 0;
    seen = 1'b0;
    while (!seen && guard < 600) begin
      @(negedge system_clk);
      seen = pix.pix_valid;
      guard++;
    end
    check("f3_valid_seen", int'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge system_clk);
      check("f3_hold_valid", int'(pix.pix_valid), 1);
      check("f3_hold_px", int'(pix.pix_x), 1);
      check("f3_hold_py", int'(pix.pix_y), 2);
      check("f3_hold_code", int'(pix.pix_code), 0);
      check("f3_hold_x", int'(x), 1);
      check("f3_hold_y", int'(y), 2);
    end
    @(posedge system_clk);
    #1;
    ready_force = 1'b1;
    finish_frame("f3");
    check("f3_n", rec_q.size(), 3);
    if (rec_q.size() == 3) begin
      check("f3_r0", rec_q[0].px * 100 + rec_q[0].py * 10 + rec_q[0].code, 120);
      check("f3_r1", rec_q[1].px * 100 + rec_q[1].py * 10 + rec_q[1].code, 322);
      check("f3_r2", rec_q[2].px * 100 + rec_q[2].py * 10 + rec_q[2].code, 423);
    end

    // Frame 4: reset while (4,2) is being emitted
    start_frame(1'b1);
    guard = 0;
    seen = 1'b0;
    while (!seen && guard < 600) begin
      @(negedge system_clk);
      seen = pix.pix_valid && pix.pix_x == 4'd4 && pix.pix_y == 4'd2;
      guard++;
    end
    check("f4_emit42_seen", int'(seen), 1);
    nreset = 1'b0;
    in_frame = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < N; i++) model_shadow[i] = 0;
    repeat (2) @(posedge system_clk);
    #1;
    check_reset_outputs("rst_hold");
    nreset = 1'b1;

    // Frame 5: diff after reset re-sends every non-empty cell; stray frame_start ignored
    ready_mode = 1'b1;
    start_frame(1'b0);
    repeat (20) @(posedge system_clk);
    #1;
    frame_start = 1'b1;
    full_refresh = 1'b1;
    @(posedge system_clk);
    #1;
    frame_start = 1'b0;
    full_refresh = 1'b0;
    finish_frame("f5");
    check("f5_n", rec_q.size(), 4);
    if (rec_q.size() == 4) check("f5_r42", rec_q[2].px * 100 + rec_q[2].py * 10 + rec_q[2].code, 423);
    repeat (30) @(negedge system_clk);
    check("f5_no_restart_busy", int'(busy), 0);
    check("f5_done_once", done_cnt, 1);

    // Classification table on a full-refresh frame
    clear_board();
    foreach (table_v[i]) place(table_v[i].cx, table_v[i].cy, table_v[i].h, table_v[i].b, table_v[i].a);
    start_frame(1'b1);
    finish_frame("tbl");
    for (int i = 0; i < 8; i++) begin
      if (rec_q.size() == 256)
        check("tbl_code", rec_q[table_v[i].cy*16 + table_v[i].cx].code, table_v[i].code);
      else
        check("tbl_size", rec_q.size(), 256);
    end

    // Randomized boards, refresh modes and writer back-pressure
    for (int f = 0; f < 8; f++) begin
      clear_board();
      place(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
      for (int b = 0; b < int'($urandom_range(0, 6)); b++)
        place(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
      place(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
      ready_mode = 1'($urandom_range(0, 1));
      start_frame($urandom_range(0, 3) == 0);
      finish_frame("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grid_scan_renderer.md
Name: grid_scan_renderer

Overview:
- Query side of the snake body/apple occupancy interface.
- Walks the 16x16 playfield row-major and drives cell coordinates x,y to the body block and the apple block.
- Samples their combinational head/body/apple flags and classifies each cell into a 2-bit code.
- Streams the changed cells, or all cells on full refresh, to the display writer over a valid/ready handshake. Keeps a shadow of the last emitted frame to do this.

Parameters:
- COORD_W, 4, coordinate width; grid is 2^COORD_W x 2^COORD_W cells.
- NUM_CELLS, 256, 2^(2*COORD_W); derived, not overridden.

Ports:
- system_clk  input  1  system clock
- nreset  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle request to scan one frame
- full_refresh  input  1  sampled with frame_start; 1 = emit every cell
- x  output  COORD_W  column being queried
- y  output  COORD_W  row being queried
- head  input  1  combinational: (x,y) is the snake head
- body  input  1  combinational: (x,y) is a body segment
- apple  input  1  combinational: (x,y) is the apple
- pix_valid  output  1  pixel record valid
- pix_ready  input  1  display writer accepts record
- pix_x  output  COORD_W  record column
- pix_y  output  COORD_W  record row
- pix_code  output  2  00 empty, 01 apple, 10 body, 11 head
- pix_last  output  1  record is cell (15,15) of the frame
- busy  output  1  scan in progress
- frame_done  output  1  one-cycle pulse when a scan completes

Behaviour:
Reset:
- State IDLE; x=y=0; pix_* = 0; busy=0; frame_done=0.
- All shadow entries = 00.
- Reset mid-frame aborts the scan immediately, drops any pending record and clears the shadow.

Classification:
- Priority head > body > apple > empty.
- Flags are sampled in the same cycle x,y are presented; x,y are registered outputs.

States:
- IDLE: busy=0.
  - frame_start=1 → latch full_refresh into refresh_q, set x=y=0, go QUERY.
  - frame_start outside IDLE is ignored.
- QUERY: busy=1; code computed from flags.
  - If refresh_q=1 or code != shadow[y][x]: register pix_x=x, pix_y=y, pix_code=code, pix_last=(x==15 && y==15), set pix_valid=1, go EMIT.
  - Otherwise advance the cell; after cell (15,15) go DONE, else stay in QUERY. Skipped cells cost exactly 1 cycle.
- EMIT: pix_valid=1; pix_x, pix_y, pix_code and pix_last are held stable until pix_ready=1.
  - On handshake (valid&&ready): write shadow[pix_y][pix_x]=pix_code, clear pix_valid, advance the cell.
  - Then go DONE if pix_last, else QUERY.
  - Minimum 2 cycles per emitted cell. x,y stay frozen on the emitted cell while waiting.
- DONE: frame_done=1 for exactly one cycle, busy=0, go IDLE.

Advance and wrap:
- x increments; when x wraps 15→0, y increments. y never wraps within a frame.
- x=y=0 on return to IDLE.

Other rules:
- pix_valid never deasserts without a handshake; no combinational path from pix_ready to pix_valid.
- The shadow updates only on handshake, so an aborted (reset) record is re-sent on the next frame.
- Empty frame diff: zero records are emitted and frame_done asserts 257 cycles after frame_start (256 QUERY cycles + DONE).

Test Plan:
- Reset, then frame_start with full_refresh=1, pix_ready tied 1, head at (3,2), body at (2,2),(1,2), apple at (9,9) → 256 records in row-major order. Codes: (3,2)=11, (2,2)=10, (1,2)=10, (9,9)=01, all others 00. pix_last only on (15,15); frame_done one cycle later.
- Second frame, full_refresh=0, unchanged board → zero pix_valid cycles; frame_done exactly 257 cycles after frame_start; busy high throughout.
- Snake moves: head to (4,2), body (3,2),(2,2) → exactly 3 records in order: (1,2)=00, (3,2)=10, (4,2)=11.
- Head and body both asserted at (5,5), full_refresh=1 → (5,5) reported as code 11.
- Hold pix_ready=0 for 10 cycles on the first emitted record → pix_valid, pix_x/pix_y/pix_code stable for all 10 cycles; x,y frozen; on ready=1 the record is accepted exactly once.
- Assert nreset=0 during EMIT of (4,2), then run a diff frame → outputs at reset values immediately. After reset the shadow is all 00, so the diff frame emits every non-empty cell, including (4,2)=11. A frame_start pulse during busy has no effect.
